instr_dispatch_fsm: RTL and testbench
=====================================

Name: instr_dispatch_fsm

Overview:
- Top-level control sequencer. Fetches an instruction word, decodes the 4-bit opcode, and issues a one-cycle one-hot nextFSM start pulse to exactly one execution sub-FSM: ALU 2-operand, ALU 1-operand/immediate, ALU NOT, Move, Movi, Load or Store.
- Waits for that sub-FSM's single-cycle completion pulse, then fetches the next instruction.
- It is the initiator side of the nextFSM/res* start-done protocol; the execution sub-FSMs are the responders.

Parameters:
- TIMEOUT, 64, max cycles in WAIT_DONE before declaring an error; legal range 2..255.
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; while high, the sequencer keeps fetching and executing.
- fetchReq  out  1  high while a fetch is outstanding.
- fetchDone  in  1  one-cycle pulse; instrIn is valid in the same cycle.
- instrIn  in  16  [15:12] opcode, [11:6] para1, [5:0] para2.
- nextFSM  out  7  one-hot start pulse; 7'b1111111 means error.
- para1  out  6  latched operand field, held until the next decode.
- para2  out  6  latched operand field, held until the next decode.
- resVec  in  7  completion pulses, one bit per sub-FSM, same bit order as nextFSM.
- busy  out  1  high in every state except IDLE and ERROR.
- errFlag  out  1  sticky error indicator.
- errCode  out  2  01 illegal opcode, 10 timeout, 11 stray/mismatched done.

Behaviour:
Reset (rst=0, async):
- state=IDLE.
- nextFSM=7'b0000000; fetchReq=0; para1=0; para2=0; busy=0; errFlag=0; errCode=00; timeout counter=0.
- Reset mid-operation aborts immediately; no pulse is reissued after reset releases.

States and transitions:
- IDLE: if run=1, go to FETCH on the next edge.
- FETCH: fetchReq=1. On fetchDone=1, register instrIn and go to DECODE. If run drops, stay until fetchDone, then go to IDLE. Never abandon an outstanding fetch.
- DECODE: register para1/para2 and select the target one-hot code:
  - 0001–0110 → 7'b0000001 (ALU 2-operand)
  - 1000, 1001 → 7'b0000010 (ALU 1-operand/immediate)
  - 0111 → 7'b0000100 (ALU NOT)
  - 1010 → 7'b0001000 (Move)
  - 1011 → 7'b0010000 (Movi)
  - 1100 → 7'b0100000 (Load)
  - 1101 → 7'b1000000 (Store)
  - 0000, 1110, 1111 → go to ERROR with errCode=01.
- ISSUE: nextFSM = selected code for exactly one cycle; clear the timeout counter; go to WAIT_DONE. nextFSM must be 0 in every other state. Holding it would pin the responder in its start state.
- WAIT_DONE: increment the counter each cycle.
  - resVec == selected code: go to FETCH if run=1, else IDLE.
  - resVec nonzero but different from the selected code: go to ERROR, errCode=11.
  - Counter reaches TIMEOUT-1 with no done: go to ERROR, errCode=10.
  - A done and the timeout in the same cycle: the done wins.
- ERROR: nextFSM=7'b1111111 for one cycle on entry, then 0. errFlag=1. The block stays in ERROR until reset; run is ignored.

Other rules:
- Any resVec pulse seen outside WAIT_DONE sets errFlag with errCode=11 but does not change state.
- Latency, fetchDone to nextFSM pulse: 2 cycles (DECODE, ISSUE).
- Latency, matching done to fetchReq reasserted: 1 cycle.

Optional Feature:
- Macro: DISPATCH_PERF_EN.
- When defined, add output retired[15:0]. It increments by 1 on each matching done in WAIT_DONE, wraps 16'hFFFF→0, and resets to 0.
- Also add output stallCyc[15:0]. It counts WAIT_DONE cycles and saturates at 16'hFFFF.
- When not defined, neither port exists and no counter logic is generated.

Test Plan:
- Movi dispatch: reset, run=1, fetchDone with instrIn=16'hB002. Required: para2=6'd2; nextFSM=7'b0010000 for exactly 1 cycle, 2 cycles after fetchDone. Then resVec=7'b0010000 pulse 5 cycles later → fetchReq=1 the next cycle.
- Decode sweep: opcodes 0001–1101 each followed by the correct done. Required: each nextFSM matches the map; errFlag stays 0; with DISPATCH_PERF_EN, retired=13.
- Illegal opcode: instrIn=16'hE000. Required: ERROR state, nextFSM=7'b1111111 for one cycle, errCode=01, busy=0; the block remains in ERROR with run=1.
- Timeout: issue Load and never assert a done. Required: ERROR entered exactly TIMEOUT cycles after ISSUE; errCode=10.
- Mismatched done: issue Store (7'b1000000) and pulse resVec=7'b0001000. Required: ERROR with errCode=11.
- Async reset mid-WAIT_DONE: drop rst=0 between edges. Required: all outputs go to 0 immediately. After release with run=1, the next transaction is a new fetch and the old nextFSM is not reissued.

Source files
------------

// File: rtl/instr_dispatch_fsm.sv
// Top-level dispatch sequencer: fetch, decode, one-hot start pulse to an execution sub-FSM, wait for its done.
// Optional DISPATCH_PERF_EN adds retired-instruction and stall-cycle counters.
module instr_dispatch_fsm #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        fetchReq,
    input  logic        fetchDone,
    input  logic [15:0] instrIn,
    output logic [6:0]  nextFSM,
    output logic [5:0]  para1,
    output logic [5:0]  para2,
    input  logic [6:0]  resVec,
    output logic        busy,
    output logic        errFlag,
`ifdef DISPATCH_PERF_EN
    output logic [1:0]  errCode,
    output logic [15:0] retired,
    output logic [15:0] stallCyc
`else
    output logic [1:0]  errCode
`endif
);

    localparam int unsigned CODE_W = 7;
    // Last wait cycle: the counter would reach TIMEOUT-1 on this edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_STRAY   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_ERROR
    } state_t;

    state_t             state;
    logic [15:0]        instr;
    logic [CODE_W-1:0]  sel;
    logic [CNT_W-1:0]   cnt;
    logic [CODE_W-1:0]  dec_code;

    // Opcode to one-hot target; zero marks an illegal opcode.
    function automatic logic [CODE_W-1:0] decode_op(input logic [3:0] op);
        logic [CODE_W-1:0] code;
        case (op)
            4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6: code = 7'b0000001;
            4'd8, 4'd9:       code = 7'b0000010;
            4'd7:             code = 7'b0000100;
            4'd10:            code = 7'b0001000;
            4'd11:            code = 7'b0010000;
            4'd12:            code = 7'b0100000;
            4'd13:            code = 7'b1000000;
            default:          code = 7'b0000000;
        endcase
        return code;
    endfunction

    assign dec_code = decode_op(instr[15:12]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            instr    <= 16'h0000;
            sel      <= '0;
            cnt      <= '0;
            fetchReq <= 1'b0;
            nextFSM  <= '0;
            para1    <= '0;
            para2    <= '0;
            busy     <= 1'b0;
            errFlag  <= 1'b0;
            errCode  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        fetchReq <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                // An outstanding fetch is always completed; a dropped run discards the word.
                S_FETCH: begin
                    if (fetchDone) begin
                        fetchReq <= 1'b0;
                        if (run) begin
                            instr <= instrIn;
                            state <= S_DECODE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_DECODE: begin
                    para1 <= instr[11:6];
                    para2 <= instr[5:0];
                    sel   <= dec_code;
                    if (dec_code != '0) begin
                        nextFSM <= dec_code;
                        state   <= S_ISSUE;
                    end else begin
                        nextFSM <= '1;
                        errFlag <= 1'b1;
                        errCode <= ERR_ILLEGAL;
                        busy    <= 1'b0;
                        state   <= S_ERROR;
                    end
                end
                S_ISSUE: begin
                    nextFSM <= '0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                // A matching done takes priority over a coincident timeout.
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (resVec == sel) begin
                        if (run) begin
                            fetchReq <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (resVec != '0) begin
                        nextFSM <= '1;
                        errFlag <= 1'b1;
                        errCode <= ERR_STRAY;
                        busy    <= 1'b0;
                        state   <= S_ERROR;
                    end else if (cnt == CNT_LAST) begin
                        nextFSM <= '1;
                        errFlag <= 1'b1;
                        errCode <= ERR_TIMEOUT;
                        busy    <= 1'b0;
                        state   <= S_ERROR;
                    end
                end
                S_ERROR: begin
                    nextFSM <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Done pulses with no dispatch pending are flagged without disturbing the sequence.
            if (state != S_WAIT && resVec != '0) begin
                errFlag <= 1'b1;
                errCode <= ERR_STRAY;
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    // Retired count wraps; stall count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired  <= 16'h0000;
            stallCyc <= 16'h0000;
        end else if (state == S_WAIT) begin
            if (stallCyc != 16'hFFFF) begin
                stallCyc <= stallCyc + 16'd1;
            end
            if (resVec == sel) begin
                retired <= retired + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Scoreboard bench for instr_dispatch_fsm: expected pulses queued at fetch, compared when nextFSM fires.
module tb_instr_dispatch_fsm;

    localparam int unsigned TIMEOUT = 64;
    localparam logic [6:0] EXP_MAP [16] = '{
        7'h00, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h04,
        7'h02, 7'h02, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00, 7'h00
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        fetchDone = 1'b0;
    logic [15:0] instrIn = 16'h0000;
    logic [6:0]  resVec = 7'h00;
    logic        fetchReq;
    logic [6:0]  nextFSM;
    logic [5:0]  para1;
    logic [5:0]  para2;
    logic        busy;
    logic        errFlag;
    logic [1:0]  errCode;
`ifdef DISPATCH_PERF_EN
    logic [15:0] retired;
    logic [15:0] stallCyc;
`endif

    int checks = 0;
    int errors = 0;
    logic [18:0] sb_q [$];

    always #5 clk = ~clk;

    instr_dispatch_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .fetchReq(fetchReq),
        .fetchDone(fetchDone),
        .instrIn(instrIn),
        .nextFSM(nextFSM),
        .para1(para1),
        .para2(para2),
        .resVec(resVec),
        .busy(busy),
        .errFlag(errFlag),
`ifdef DISPATCH_PERF_EN
        .errCode(errCode),
        .retired(retired),
        .stallCyc(stallCyc)
`else
        .errCode(errCode)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        run = 1'b0;
        fetchDone = 1'b0;
        resVec = 7'h00;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetchReq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Drives one fetch completion at the current negedge and queues the expected pulse.
    task automatic send_instr(input logic [15:0] w);
        logic [6:0] code;
        code = EXP_MAP[w[15:12]];
        if (code == 7'h00) code = 7'h7F;
        sb_q.push_back({code, w[11:6], w[5:0]});
        fetchDone = 1'b1;
        instrIn = w;
        @(negedge clk);
        fetchDone = 1'b0;
        instrIn = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetchReq, nextFSM, para1, para2, busy, errFlag, errCode} !== 24'h0)
            $display("FAIL reset_outputs: got %h want 000000",
                     {fetchReq, nextFSM, para1, para2, busy, errFlag, errCode});
        if ({fetchReq, nextFSM, para1, para2, busy, errFlag, errCode} !== 24'h0) errors++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({fetchReq, busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_run: fetchReq/busy got %b want 00", {fetchReq, busy});
        end
    endtask

    task automatic test_movi();
        bit ok;
        logic [18:0] exp;
        apply_reset();
        run = 1'b1;
        wait_fetch(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL movi_fetchreq: got 0 want 1"); end
        send_instr(16'hB002);
        checks++;
        if (nextFSM !== 7'h00) begin
            errors++; $display("FAIL movi_early_pulse: got %b want 0000000", nextFSM);
        end
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if ({nextFSM, para1, para2} !== exp) begin
            errors++; $display("FAIL movi_pulse: got %h want %h", {nextFSM, para1, para2}, exp);
        end
        @(negedge clk);
        checks++;
        if (nextFSM !== 7'h00 || para2 !== 6'd2) begin
            errors++; $display("FAIL movi_pulse_width: nextFSM %b para2 %0d want 0000000 2", nextFSM, para2);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (fetchReq !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL movi_waiting: fetchReq %b busy %b want 0 1", fetchReq, busy);
        end
        resVec = 7'b0010000;
        @(negedge clk);
        resVec = 7'h00;
        checks++;
        if (fetchReq !== 1'b1 || errFlag !== 1'b0) begin
            errors++; $display("FAIL movi_refetch: fetchReq %b errFlag %b want 1 0", fetchReq, errFlag);
        end
    endtask

    task automatic test_decode_sweep();
        bit ok;
        bit found;
        logic [18:0] exp;
        logic [15:0] w;
        apply_reset();
        run = 1'b1;
        for (int op = 1; op <= 13; op++) begin
            wait_fetch(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL sweep_fetchreq op %0d: got 0 want 1", op); end
            w = {4'(op), 6'(op * 3), 6'(63 - op)};
            send_instr(w);
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (nextFSM !== 7'h00) begin found = 1'b1; break; end
            end
            exp = sb_q.pop_front();
            checks++;
            if (!found || {nextFSM, para1, para2} !== exp) begin
                errors++; $display("FAIL sweep_pulse op %0d: got %h want %h", op, {nextFSM, para1, para2}, exp);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
            resVec = exp[18:12];
            @(negedge clk);
            resVec = 7'h00;
        end
        checks++;
        if (errFlag !== 1'b0) begin errors++; $display("FAIL sweep_errflag: got %b want 0", errFlag); end
`ifdef DISPATCH_PERF_EN
        checks++;
        if (retired !== 16'd13) begin errors++; $display("FAIL sweep_retired: got %0d want 13", retired); end
`endif
    endtask

    task automatic test_illegal();
        bit ok;
        logic [18:0] exp;
        apply_reset();
        run = 1'b1;
        wait_fetch(ok);
        send_instr(16'hE000);
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if ({nextFSM, errFlag, errCode, busy} !== {exp[18:12], 1'b1, 2'b01, 1'b0}) begin
            errors++; $display("FAIL illegal_entry: nextFSM %b errFlag %b errCode %b busy %b want 1111111 1 01 0",
                               nextFSM, errFlag, errCode, busy);
        end
        @(negedge clk);
        checks++;
        if (nextFSM !== 7'h00) begin errors++; $display("FAIL illegal_pulse_width: got %b want 0000000", nextFSM); end
        repeat (10) @(negedge clk);
        checks++;
        if ({fetchReq, busy, errFlag, errCode} !== 5'b00101) begin
            errors++; $display("FAIL illegal_sticky: fetchReq %b busy %b errFlag %b errCode %b want 0 0 1 01",
                               fetchReq, busy, errFlag, errCode);
        end
    endtask

    task automatic test_stray_done();
        bit ok;
        apply_reset();
        @(negedge clk);
        resVec = 7'h01;
        @(negedge clk);
        resVec = 7'h00;
        checks++;
        if ({errFlag, errCode, busy} !== 4'b1110) begin
            errors++; $display("FAIL stray_flag: errFlag %b errCode %b busy %b want 1 11 0", errFlag, errCode, busy);
        end
        run = 1'b1;
        wait_fetch(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stray_state_kept: fetchReq got 0 want 1"); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        logic [18:0] exp;
        apply_reset();
        run = 1'b1;
        wait_fetch(ok);
        send_instr(16'hC000);
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if ({nextFSM, para1, para2} !== exp) begin
            errors++; $display("FAIL timeout_issue: got %h want %h", {nextFSM, para1, para2}, exp);
        end
        n = 0;
        for (int i = 1; i <= int'(TIMEOUT) + 4; i++) begin
            @(negedge clk);
            if (errFlag === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != int'(TIMEOUT)) begin
            errors++; $display("FAIL timeout_latency: got %0d want %0d", n, TIMEOUT);
        end
        checks++;
        if (errCode !== 2'b10 || nextFSM !== 7'h7F) begin
            errors++; $display("FAIL timeout_code: errCode %b nextFSM %b want 10 1111111", errCode, nextFSM);
        end
    endtask

    task automatic test_done_at_timeout();
        bit ok;
        logic [18:0] exp;
        apply_reset();
        run = 1'b1;
        wait_fetch(ok);
        send_instr(16'hC041);
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if ({nextFSM, para1, para2} !== exp) begin
            errors++; $display("FAIL edge_issue: got %h want %h", {nextFSM, para1, para2}, exp);
        end
        repeat (TIMEOUT - 1) @(negedge clk);
        resVec = 7'h20;
        @(negedge clk);
        resVec = 7'h00;
        checks++;
        if (errFlag !== 1'b0 || fetchReq !== 1'b1) begin
            errors++; $display("FAIL edge_done_wins: errFlag %b fetchReq %b want 0 1", errFlag, fetchReq);
        end
    endtask

    task automatic test_mismatch();
        bit ok;
        logic [18:0] exp;
        apply_reset();
        run = 1'b1;
        wait_fetch(ok);
        send_instr(16'hD000);
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if ({nextFSM, para1, para2} !== exp) begin
            errors++; $display("FAIL mismatch_issue: got %h want %h", {nextFSM, para1, para2}, exp);
        end
        @(negedge clk);
        resVec = 7'b0001000;
        @(negedge clk);
        resVec = 7'h00;
        checks++;
        if ({errFlag, errCode, nextFSM, busy} !== {1'b1, 2'b11, 7'h7F, 1'b0}) begin
            errors++; $display("FAIL mismatch_error: errFlag %b errCode %b nextFSM %b busy %b want 1 11 1111111 0",
                               errFlag, errCode, nextFSM, busy);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit reissued;
        bit seen;
        logic [18:0] exp;
        apply_reset();
        run = 1'b1;
        wait_fetch(ok);
        send_instr(16'hB015);
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if ({nextFSM, para1, para2} !== exp) begin
            errors++; $display("FAIL areset_issue: got %h want %h", {nextFSM, para1, para2}, exp);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({fetchReq, nextFSM, para1, para2, busy, errFlag, errCode} !== 24'h0) begin
            errors++; $display("FAIL areset_immediate: got %h want 000000",
                               {fetchReq, nextFSM, para1, para2, busy, errFlag, errCode});
        end
        @(negedge clk);
        rst = 1'b1;
        reissued = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (nextFSM !== 7'h00) reissued = 1'b1;
            if (fetchReq === 1'b1) seen = 1'b1;
        end
        checks++;
        if (reissued || !seen) begin
            errors++; $display("FAIL areset_restart: reissued %b fetchReq_seen %b want 0 1", reissued, seen);
        end
        send_instr(16'hA000);
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if ({nextFSM, para1, para2} !== exp) begin
            errors++; $display("FAIL areset_new_txn: got %h want %h", {nextFSM, para1, para2}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_movi();
        test_decode_sweep();
        test_illegal();
        test_stray_done();
        test_timeout();
        test_done_at_timeout();
        test_mismatch();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
